// File: rtl/writeback_regfile.sv
// writeback_regfile: writeback decode, 16x20 register file with r0 hardwired to zero, bypassed read ports, retire counter
// Ports: clock/reset (sync, active-high); wb_valid, wb_instruction, wb_alu_result, wb_mem_data from MEM/WB;
//        rs_addr/rt_addr -> rs_data/rt_data; wb_write_en/addr/data commit view; retire_count.
module writeback_regfile #(
  parameter logic [3:0] OP_NOP = 4'h0,
  parameter logic [3:0] OP_LW  = 4'h1,
  parameter logic [3:0] OP_SW  = 4'h2,
  parameter logic [3:0] OP_BEQ = 4'h3,
  parameter logic [3:0] OP_J   = 4'h4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [19:0] wb_instruction,
  input  logic [19:0] wb_alu_result,
  input  logic [19:0] wb_mem_data,
  input  logic [3:0]  rs_addr,
  input  logic [3:0]  rt_addr,
  output logic [19:0] rs_data,
  output logic [19:0] rt_data,
  output logic        wb_write_en,
  output logic [3:0]  wb_write_addr,
  output logic [19:0] wb_write_data,
  output logic [15:0] retire_count
);
  logic [19:0] regs [16];
  logic [3:0]  op;
  logic        writes;
  logic        unused;
  assign op            = wb_instruction[19:16];
  assign wb_write_addr = wb_instruction[15:12];
  assign unused        = ^wb_instruction[11:0];
  assign writes        = !(op == OP_NOP || op == OP_SW || op == OP_BEQ || op == OP_J);
  assign wb_write_data = (op == OP_LW) ? wb_mem_data : wb_alu_result;
  assign wb_write_en   = wb_valid & writes & (wb_write_addr != 4'd0) & ~reset;
  // Bypass lets decode see the value being committed this cycle without a stall
  always_comb begin
    rs_data = (rs_addr == 4'd0) ? 20'h0 : (wb_write_en && wb_write_addr == rs_addr) ? wb_write_data : regs[rs_addr];
    rt_data = (rt_addr == 4'd0) ? 20'h0 : (wb_write_en && wb_write_addr == rt_addr) ? wb_write_data : regs[rt_addr];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= 20'h0;
      retire_count <= 16'h0;
    end else begin
      if (wb_write_en) regs[wb_write_addr] <= wb_write_data;
      if (wb_valid && op != OP_NOP) retire_count <= retire_count + 16'd1;
    end
  end
endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Writeback stage and architectural register file of the 20-bit pipelined processor. It consumes the MEM/WB pipeline register outputs (instruction, ALU result, memory read data). It decides per opcode whether and what to write back, and commits the value into a 16 × 20-bit register file. It serves the decode stage's two read ports, with same-cycle write-through bypass, and keeps a retired-instruction counter for debug and performance.

## Interface
Parameters:
- OP_NOP, 4'h0, no-operation opcode; no writeback.
- OP_LW, 4'h1, load; writes memory read data.
- OP_SW, 4'h2, store; no writeback.
- OP_BEQ, 4'h3, branch; no writeback.
- OP_J, 4'h4, jump; no writeback.

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high.
- wb_valid, in, 1, MEM/WB slot holds a real instruction (0 = bubble).
- wb_instruction, in, 20, instruction in WB: opcode [19:16], rd [15:12], rs [11:8], rt [7:4].
- wb_alu_result, in, 20, ALU result from MEM/WB.
- wb_mem_data, in, 20, memory read data from MEM/WB.
- rs_addr, in, 4, decode read port A address.
- rt_addr, in, 4, decode read port B address.
- rs_data, out, 20, read port A data.
- rt_data, out, 20, read port B data.
- wb_write_en, out, 1, register write committed at the next edge.
- wb_write_addr, out, 4, destination register (rd).
- wb_write_data, out, 20, value being written.
- retire_count, out, 16, count of retired non-NOP instructions.

## Operation
- Decode of wb_instruction is combinational: op = [19:16], rd = [15:12].
- Write class:
  - op ∈ {OP_NOP, OP_SW, OP_BEQ, OP_J}: no write.
  - op = OP_LW: data = wb_mem_data.
  - All other opcodes (4'h5–4'hF): data = wb_alu_result.
- wb_write_en = wb_valid & writes(op) & (rd != 0) & ~reset.
- wb_write_addr = rd. wb_write_data = the selected data, driven even when wb_write_en = 0.
- Register r0 is hardwired to 0. Writes to r0 are discarded and r0 always reads 20'h0.
- Register file: 16 × 20 bits, updated at the rising edge when wb_write_en = 1.
- Read ports are combinational. rs_data:
  - 0 if rs_addr = 0;
  - else wb_write_data if wb_write_en and wb_write_addr = rs_addr (write-through bypass);
  - else the stored register value.
  - rt_data follows the same rule with rt_addr.
- Both read ports may select the same register, or the register being written; each port resolves independently.
- retire_count increments by 1 at each edge where wb_valid = 1 and op != OP_NOP, whether or not the instruction writes a register. It wraps 16'hFFFF → 16'h0000 with no saturation.
- Reset (synchronous) clears all 16 registers and retire_count to 0. A write present in the same cycle as reset is dropped. A reset asserted mid-program discards all architectural state.

## Timing
- Write latency: the value presented in cycle N is stored at the edge ending cycle N. Through the bypass it is visible on rs_data/rt_data during cycle N itself, so decode needs no extra stall for a WB→ID dependency.
- Reads are combinational from the address and WB inputs, with no registered output.
- Reset values:
  - rs_data/rt_data: 0 for every address in the cycle after reset deasserts.
  - wb_write_en: 0 while reset = 1.
  - retire_count: 0.
  - wb_write_addr and wb_write_data follow their inputs combinationally.
- Back-to-back writes to the same rd on consecutive cycles: the last write wins. A read in the second cycle returns the second value via bypass.
- A bubble (wb_valid = 0) performs no write and no count, regardless of the instruction bits.

## Test plan
- Reset then read: assert reset 1 cycle, deassert → rs_data = rt_data = 0 for all addresses 0..15; retire_count = 0.
- ALU writeback plus bypass: wb_valid = 1, instr = 20'h5_3_00_0 (op 5, rd 3), alu = 20'hABCDE, rs_addr = 3 → rs_data = 20'hABCDE in the same cycle. Next cycle with wb_valid = 0 → still 20'hABCDE; retire_count = 1.
- Load versus store: LW to rd 7 with mem = 20'h12345, alu = 20'hFFFFF → r7 = 20'h12345. Then SW with rd field 7, alu = 20'h00001 → r7 unchanged; retire_count = 2, wb_write_en = 0 during SW.
- r0 and bubbles:
  - ALU op to rd 0 with alu = 20'h55555 → wb_write_en = 0 and r0 reads 0.
  - wb_valid = 0 with a valid-looking ALU instr to rd 4 → r4 unchanged and retire_count unchanged.
- Counter wrap and NOP: retire 65 536 non-NOP instructions → retire_count returns to 0. Interleaved OP_NOP with wb_valid = 1 does not count.
- Reset mid-operation: write r9 = 20'h0F0F0, then assert reset in the same cycle as a write r9 = 20'h11111 → after reset, r9 = 0 and retire_count = 0.
